// File: rtl/vu_level_meter_if.sv
`default_nettype none
// vu_level_meter_if: sample input and meter output bundle for vu_level_meter. Rev 1.0
interface vu_level_meter_if #(
  parameter int N_LEDS = 8
);
  logic [11:0]       sample;
  logic              sample_valid;
  logic              clip_clr;
  logic [10:0]       level;
  logic [N_LEDS-1:0] leds;
  logic              clip;

  modport master (
    output sample, sample_valid, clip_clr,
    input  level, leds, clip
  );

  modport slave (
    input  sample, sample_valid, clip_clr,
    output level, leds, clip
  );
endinterface
`default_nettype wire

// File: rtl/vu_level_meter.sv
`default_nettype none
// vu_level_meter: rectify ADC samples about mid-scale, track peak with hold and linear decay,
// drive a thermometer LED bar and a sticky clip flag. Rev 1.0
module vu_level_meter #(
  parameter int N_LEDS      = 8,
  parameter int MIDSCALE    = 2048,
  parameter int HOLD_CYCLES = 1 << 20,
  parameter int DECAY_DIV   = 1 << 14,
  parameter int DECAY_STEP  = 16
) (
  input  logic             clk,
  input  logic             rst,
  vu_level_meter_if.slave  bus
);
  localparam int HW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int DW   = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam int STEP = 2048 / N_LEDS;
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DECAY_LOAD = DW'(DECAY_DIV - 1);
  localparam logic [10:0]   DEC_AMT    = 11'(DECAY_STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_DECAY = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [10:0]       mag, level_q, level_n;
  logic              mag_vld, clip_q, attack;
  logic [HW-1:0]     hold_cnt, hold_n;
  logic [DW-1:0]     decay_cnt, decay_n;
  logic [N_LEDS-1:0] leds_q, bar;
  logic [12:0]       diff, mag_abs;
  logic [10:0]       mag_sat;

  // Two's complement difference; its sign bit is valid because |diff| < 4096.
  assign diff    = {1'b0, bus.sample} - 13'(MIDSCALE);
  assign mag_abs = diff[12] ? (13'd0 - diff) : diff;
  assign mag_sat = (mag_abs > 13'd2047) ? 11'd2047 : mag_abs[10:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      mag     <= '0;
      mag_vld <= 1'b0;
      clip_q  <= 1'b0;
    end else begin
      mag_vld <= bus.sample_valid;
      if (bus.sample_valid)
        mag <= mag_sat;
      if (bus.sample_valid && (bus.sample == 12'd0 || bus.sample == 12'hFFF))
        clip_q <= 1'b1;
      else if (bus.clip_clr)
        clip_q <= 1'b0;
    end
  end

  // A zero magnitude never counts as an attack, so IDLE stays IDLE on silence.
  assign attack = mag_vld && (mag >= level_q) && (mag != 11'd0);

  always_comb begin
    state_n = state;
    level_n = level_q;
    hold_n  = hold_cnt;
    decay_n = decay_cnt;
    if (attack) begin
      level_n = mag;
      hold_n  = HOLD_LOAD;
      state_n = S_HOLD;
    end else begin
      case (state)
        S_IDLE: level_n = '0;
        S_HOLD: begin
          if (hold_cnt == '0) begin
            decay_n = DECAY_LOAD;
            state_n = S_DECAY;
          end else begin
            hold_n = hold_cnt - 1'b1;
          end
        end
        S_DECAY: begin
          if (decay_cnt == '0) begin
            decay_n = DECAY_LOAD;
            level_n = (level_q > DEC_AMT) ? (level_q - DEC_AMT) : 11'd0;
            if (level_n == 11'd0)
              state_n = S_IDLE;
          end else begin
            decay_n = decay_cnt - 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      level_q   <= '0;
      hold_cnt  <= '0;
      decay_cnt <= '0;
      leds_q    <= '0;
    end else begin
      state     <= state_n;
      level_q   <= level_n;
      hold_cnt  <= hold_n;
      decay_cnt <= decay_n;
      leds_q    <= bar;
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_bar
    localparam int THR = i * STEP + STEP / 2;
    assign bar[i] = (level_q >= 11'(THR));
  end

  assign bus.level = level_q;
  assign bus.leds  = leds_q;
  assign bus.clip  = clip_q;
endmodule
`default_nettype wire

// File: tb/tb_vu_level_meter.sv
`default_nettype none
// tb_vu_level_meter: scoreboard bench; a time-based peak/hold/decay model predicts every cycle's outputs.
module tb_vu_level_meter;
  localparam int N_LEDS = 8;
  localparam int HOLD   = 16;
  localparam int DIV    = 4;
  localparam int STEP   = 64;
  localparam int MID    = 2048;
  localparam int SEG    = 2048 / N_LEDS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vu_level_meter_if #(.N_LEDS(N_LEDS)) bus ();

  vu_level_meter #(
    .N_LEDS(N_LEDS), .MIDSCALE(MID), .HOLD_CYCLES(HOLD),
    .DECAY_DIV(DIV), .DECAY_STEP(STEP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int lvl;
    int bar;
    int clp;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Model: level is a function of the last attack's value and the time elapsed since it.
  int m_level, m_leds, m_clip, m_mag, m_magv;
  int att_edge, att_val, edge_n;

  function automatic int bar_of(input int lv);
    int cnt;
    cnt = (lv + SEG / 2) / SEG;
    if (cnt > N_LEDS) cnt = N_LEDS;
    return (1 << cnt) - 1;
  endfunction

  function automatic int decayed(input int e);
    int d, v;
    if (att_val == 0) return 0;
    d = e - att_edge;
    if (d <= HOLD) return att_val;
    v = att_val - STEP * ((d - HOLD) / DIV);
    return (v < 0) ? 0 : v;
  endfunction

  function automatic int rect(input int s);
    int m;
    m = (s >= MID) ? s - MID : MID - s;
    return (m > 2047) ? 2047 : m;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)", nm, $time, act, act, exp_v, exp_v);
    end
  endtask

  // Drive one cycle of inputs, predict the outputs after the coming edge, push, advance.
  task automatic step(input logic r, input int s, input logic v, input logic c);
    exp_t e;
    int prev;
    rst              = r;
    bus.sample       = 12'(s);
    bus.sample_valid = v;
    bus.clip_clr     = c;
    edge_n++;
    if (r) begin
      m_level = 0; m_leds = 0; m_clip = 0; m_mag = 0; m_magv = 0; att_val = 0;
    end else begin
      prev   = m_level;
      m_leds = bar_of(prev);
      if (m_magv != 0 && m_mag > 0 && m_mag >= prev) begin
        att_edge = edge_n;
        att_val  = m_mag;
        m_level  = m_mag;
      end else begin
        m_level = decayed(edge_n);
      end
      m_magv = v ? 1 : 0;
      if (v) m_mag = rect(s);
      if (v && (s == 0 || s == 4095)) m_clip = 1;
      else if (c) m_clip = 0;
    end
    e.lvl = m_level; e.bar = m_leds; e.clp = m_clip;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, MID, 1'b0, 1'b0);
  endtask

  task automatic send(input int s);
    step(1'b0, s, 1'b1, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        @(negedge clk);
        check("level", {21'd0, bus.level}, e.lvl);
        check("leds",  {24'd0, bus.leds},  e.bar);
        check("clip",  {31'd0, bus.clip},  e.clp);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected end");
    $fatal(1);
  end

  initial begin : driver
    int s, guard;
    edge_n = 0; att_edge = 0; att_val = 0;
    m_level = 0; m_leds = 0; m_clip = 0; m_mag = 0; m_magv = 0;

    step(1'b1, MID, 1'b0, 1'b0);
    step(1'b1, MID, 1'b0, 1'b0);
    idle(2);

    send(1024);
    idle(90);

    send(4095);
    idle(4);
    send(2048);
    idle(3);
    step(1'b0, MID, 1'b0, 1'b1);
    idle(2);

    step(1'b0, 0, 1'b1, 1'b1);
    idle(4);

    step(1'b1, MID, 1'b0, 1'b0);
    send(MID + 1024);
    guard = 0;
    while (m_level != 896 && guard < 200) begin
      idle(1);
      guard++;
    end
    check("reach_896", guard < 200, 1);
    send(3000);
    idle(100);

    send(MID + 200);
    send(MID - 500);
    send(MID + 100);
    idle(5);
    step(1'b1, MID, 1'b0, 1'b0);
    idle(3);

    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 15))
        0:       s = 0;
        1:       s = 4095;
        2:       s = MID;
        default: s = $urandom_range(0, 4095);
      endcase
      step($urandom_range(0, 499) == 0, s, $urandom_range(0, 5) == 0,
           $urandom_range(0, 19) == 0);
    end
    idle(3);

    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
